// File: rtl/signed_sequential_divider.sv
// Multi-cycle signed integer divider: restoring division on operand magnitudes,
// one quotient bit per clock, followed by a single sign-correction cycle.
module signed_sequential_divider #(
    parameter int N = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                Start,
    input  logic signed [N-1:0] Dividend,
    input  logic signed [N-1:0] Divisor,
    output logic                Busy,
    output logic                Done,
    output logic signed [N-1:0] Quotient,
    output logic signed [N-1:0] Remainder,
    output logic                DivByZero
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [N-1:0]  prem;
    logic [N-1:0]  dd_mag;
    logic [N-1:0]  dv_mag;
    logic          qneg;
    logic          rneg;
    logic          dz;
    logic [N:0]    shifted;
    logic [N:0]    trial;

    // Magnitude as an unsigned N-bit value; the most-negative input maps to 2^(N-1).
    function automatic logic [N-1:0] mag(input logic signed [N-1:0] x);
        logic [N-1:0] u;
        u = x;
        return x[N-1] ? -u : u;
    endfunction

    function automatic logic signed [N-1:0] apply_sign(input logic [N-1:0] m, input logic neg);
        logic [N-1:0] r;
        r = neg ? -m : m;
        return signed'(r);
    endfunction

    // Partial remainder is kept below the divisor, so the shifted value fits in N+1 bits.
    always_comb begin
        shifted = {1'b0, prem, dd_mag[N-1]} >> 0;
        shifted = {prem, dd_mag[N-1]};
        trial   = shifted - {1'b0, dv_mag};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        Busy      = 1'b0;
        case (state)
            IDLE: begin
                if (Start) state_nxt = (Divisor == '0) ? FIX : CALC;
            end
            CALC: begin
                Busy = 1'b1;
                if (cnt == CW'(1)) state_nxt = FIX;
            end
            FIX: begin
                Busy      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            prem      <= '0;
            dd_mag    <= '0;
            dv_mag    <= '0;
            qneg      <= 1'b0;
            rneg      <= 1'b0;
            dz        <= 1'b0;
            Done      <= 1'b0;
            Quotient  <= '0;
            Remainder <= '0;
            DivByZero <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        qneg <= Dividend[N-1] ^ Divisor[N-1];
                        rneg <= Dividend[N-1];
                        prem <= '0;
                        cnt  <= CW'(N);
                        if (Divisor == '0) begin
                            // Raw dividend is parked here to become the remainder.
                            dz     <= 1'b1;
                            dd_mag <= Dividend;
                            dv_mag <= '0;
                        end else begin
                            dz     <= 1'b0;
                            dd_mag <= mag(Dividend);
                            dv_mag <= mag(Divisor);
                        end
                    end
                end
                CALC: begin
                    if (!trial[N]) begin
                        prem   <= trial[N-1:0];
                        dd_mag <= {dd_mag[N-2:0], 1'b1};
                    end else begin
                        prem   <= shifted[N-1:0];
                        dd_mag <= {dd_mag[N-2:0], 1'b0};
                    end
                    cnt <= cnt - CW'(1);
                end
                FIX: begin
                    Done      <= 1'b1;
                    DivByZero <= dz;
                    if (dz) begin
                        Quotient  <= '1;
                        Remainder <= signed'(dd_mag);
                    end else begin
                        Quotient  <= apply_sign(dd_mag, qneg);
                        Remainder <= apply_sign(prem, rneg);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_signed_sequential_divider.sv
// Directed and randomized checks of signed_sequential_divider at N = 32.
module tb_signed_sequential_divider;

    logic               clk = 1'b0;
    logic               rst;
    logic               Start;
    logic signed [31:0] Dividend;
    logic signed [31:0] Divisor;
    logic               Busy;
    logic               Done;
    logic signed [31:0] Quotient;
    logic signed [31:0] Remainder;
    logic               DivByZero;

    int checks = 0;
    int errors = 0;

    signed_sequential_divider #(.N(32)) dut (
        .clk(clk), .rst(rst), .Start(Start), .Dividend(Dividend), .Divisor(Divisor),
        .Busy(Busy), .Done(Done), .Quotient(Quotient), .Remainder(Remainder),
        .DivByZero(DivByZero)
    );

    always #5 clk = ~clk;

    // Issues one request and waits (bounded) for Done; lat = -1 on timeout.
    task automatic run_div(input logic signed [31:0] a, input logic signed [31:0] b,
                           output int lat, output logic signed [31:0] q,
                           output logic signed [31:0] r, output logic z);
        @(negedge clk);
        Dividend = a; Divisor = b; Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (Done) begin lat = i; break; end
        end
        q = Quotient; r = Remainder; z = DivByZero;
    endtask

    task automatic test_reset();
        rst = 1'b1; Start = 1'b0; Dividend = '0; Divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({Busy, Done, DivByZero} !== 3'b000 || Quotient !== 32'sd0 || Remainder !== 32'sd0) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b dz=%b q=%0d r=%0d required all 0",
                     Busy, Done, DivByZero, Quotient, Remainder);
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_basic();
        int lat;
        logic busy_bad;
        @(negedge clk);
        Dividend = 100; Divisor = 7; Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
        checks++;
        if (Busy !== 1'b1) begin
            errors++; $display("FAIL basic_busy_accept: busy=%b required 1", Busy);
        end
        busy_bad = 1'b0;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (i <= 32 && (Busy !== 1'b1 || Done !== 1'b0)) busy_bad = 1'b1;
            if (Done) begin lat = i; break; end
        end
        checks++;
        if (busy_bad) begin
            errors++; $display("FAIL basic_busy_window: busy/done wrong in cycles 1..32");
        end
        checks++;
        if (lat !== 33) begin
            errors++; $display("FAIL basic_latency: got %0d required 33", lat);
        end
        checks++;
        if (Busy !== 1'b0 || Quotient !== 32'sd14 || Remainder !== 32'sd2 || DivByZero !== 1'b0) begin
            errors++;
            $display("FAIL basic_100_7: busy=%b q=%0d r=%0d dz=%b required busy 0 q 14 r 2 dz 0",
                     Busy, Quotient, Remainder, DivByZero);
        end
        @(posedge clk); #1;
        checks++;
        if (Done !== 1'b0) begin
            errors++; $display("FAIL basic_done_pulse: done=%b required 0 after pulse", Done);
        end
    endtask

    task automatic test_signs_extremes();
        logic signed [31:0] va [8] = '{100, -100, 100, -100, 0, 7, 32'h80000000, 32'h80000000};
        logic signed [31:0] vb [8] = '{7, 7, -7, -7, 5, 100, -1, 1};
        logic signed [31:0] eq [8] = '{14, -14, -14, 14, 0, 0, 32'h80000000, 32'h80000000};
        logic signed [31:0] er [8] = '{2, -2, 2, -2, 0, 7, 0, 0};
        int lat;
        logic signed [31:0] q, r;
        logic z;
        for (int i = 0; i < 8; i++) begin
            run_div(va[i], vb[i], lat, q, r, z);
            checks++;
            if (lat !== 33 || q !== eq[i] || r !== er[i] || z !== 1'b0) begin
                errors++;
                $display("FAIL sign_vec%0d %0d/%0d: lat=%0d q=%0d r=%0d dz=%b required lat 33 q %0d r %0d dz 0",
                         i, va[i], vb[i], lat, q, r, z, eq[i], er[i]);
            end
        end
        run_div(32'h7FFFFFFF, 32'h80000000, lat, q, r, z);
        checks++;
        if (q !== 32'sd0 || r !== 32'sh7FFFFFFF || z !== 1'b0) begin
            errors++;
            $display("FAIL max_by_min: q=%h r=%h dz=%b required 0 7fffffff 0", q, r, z);
        end
    endtask

    task automatic test_div_by_zero();
        int lat;
        logic signed [31:0] q, r;
        logic z;
        run_div(1234, 0, lat, q, r, z);
        checks++;
        if (lat !== 1 || q !== -32'sd1 || r !== 32'sd1234 || z !== 1'b1) begin
            errors++;
            $display("FAIL div0: lat=%0d q=%h r=%0d dz=%b required lat 1 q ffffffff r 1234 dz 1",
                     lat, q, r, z);
        end
        run_div(9, 3, lat, q, r, z);
        checks++;
        if (lat !== 33 || q !== 32'sd3 || r !== 32'sd0 || z !== 1'b0) begin
            errors++;
            $display("FAIL after_div0: lat=%0d q=%0d r=%0d dz=%b required 33 3 0 0", lat, q, r, z);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge clk);
        Dividend = 50; Divisor = 5; Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            if (i == 10) begin
                Dividend = 9; Divisor = 2; Start = 1'b1;
            end
            @(posedge clk); #1;
            Start = 1'b0;
            if (Done) begin lat = i; break; end
        end
        checks++;
        if (lat !== 33 || Quotient !== 32'sd10 || Remainder !== 32'sd0) begin
            errors++;
            $display("FAIL busy_ignore: lat=%0d q=%0d r=%0d required 33 10 0", lat, Quotient, Remainder);
        end
        // Request issued inside the Done cycle.
        Dividend = 9; Divisor = 2; Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
        checks++;
        if (Done !== 1'b0 || Busy !== 1'b1 || Quotient !== 32'sd10) begin
            errors++;
            $display("FAIL b2b_accept: done=%b busy=%b q=%0d required 0 1 10", Done, Busy, Quotient);
        end
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (Done) begin lat = i; break; end
        end
        checks++;
        if (lat !== 33 || Quotient !== 32'sd4 || Remainder !== 32'sd1) begin
            errors++;
            $display("FAIL b2b_result: lat=%0d q=%0d r=%0d required 33 4 1", lat, Quotient, Remainder);
        end
    endtask

    task automatic test_reset_abort();
        int lat;
        logic seen_done;
        logic signed [31:0] q, r;
        logic z;
        @(negedge clk);
        Dividend = 1000; Divisor = 3; Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
        repeat (15) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({Busy, Done, DivByZero} !== 3'b000 || Quotient !== 32'sd0 || Remainder !== 32'sd0) begin
            errors++;
            $display("FAIL reset_abort: busy=%b done=%b dz=%b q=%0d r=%0d required all 0",
                     Busy, Done, DivByZero, Quotient, Remainder);
        end
        @(negedge clk); @(negedge clk); rst = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (Done) seen_done = 1'b1;
        end
        checks++;
        if (seen_done !== 1'b0 || Busy !== 1'b0) begin
            errors++; $display("FAIL abort_no_done: done_seen=%b busy=%b required 0 0", seen_done, Busy);
        end
        run_div(21, 4, lat, q, r, z);
        checks++;
        if (lat !== 33 || q !== 32'sd5 || r !== 32'sd1 || z !== 1'b0) begin
            errors++;
            $display("FAIL after_abort: lat=%0d q=%0d r=%0d dz=%b required 33 5 1 0", lat, q, r, z);
        end
    endtask

    task automatic test_random();
        int lat;
        logic signed [31:0] a, b, q, r, eq, er;
        logic z;
        for (int n = 0; n < 1500; n++) begin
            a = $urandom;
            b = (n % 3 == 0) ? 32'($signed($urandom_range(0, 200)) - 100) : $urandom;
            if (b == 0) b = 1;
            if (a == 32'sh80000000 && b == -32'sd1) b = 2;
            eq = a / b;
            er = a % b;
            run_div(a, b, lat, q, r, z);
            checks++;
            if (lat !== 33 || q !== eq || r !== er || z !== 1'b0) begin
                errors++;
                $display("FAIL random %0d/%0d: lat=%0d q=%0d r=%0d required lat 33 q %0d r %0d",
                         a, b, lat, q, r, eq, er);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signs_extremes();
        test_div_by_zero();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
